// File: rtl/mult_share_arbiter_pkg.sv
// Shared configuration for the multiplier-sharing arbiter: default ALU port
// configuration and the helpers that size requester ids and counters.
package mult_share_arbiter_pkg;

    localparam int unsigned ALU_REQUESTERS = 4;
    localparam int unsigned ALU_WORD_WIDTH = 36;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A single-client configuration still needs a one-bit id field.
    function automatic int unsigned mult_arb_id_width(input int unsigned requesters);
        return (requesters < 2) ? 1 : clog2(requesters);
    endfunction

    localparam int unsigned MULT_ARB_ID_WIDTH = mult_arb_id_width(ALU_REQUESTERS);

endpackage

// File: rtl/mult_share_arbiter_tag_pipe.sv
// Resettable {valid,id} shift register that tracks which requester owns each
// product travelling through the non-stallable multiplier pipeline.
module mult_tag_pipe
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = MULT_ARB_ID_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [ID_WIDTH-1:0] id_i,
    output logic                valid_o,
    output logic [ID_WIDTH-1:0] id_o,
    output logic                busy_o
);

    logic [DEPTH-1:0]    valid_q;
    logic [ID_WIDTH-1:0] id_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            id_q[0]    <= id_i;
            for (int s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                id_q[s]    <= id_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign id_o    = id_q[DEPTH-1];
    assign busy_o  = |valid_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among several clients,
// with per-client outstanding caps and tag-based steering of returned products.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTERS      = ALU_REQUESTERS,
    parameter int unsigned WORD_WIDTH      = ALU_WORD_WIDTH,
    parameter int unsigned MULT_LATENCY    = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH        = MULT_ARB_ID_WIDTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [REQUESTERS-1:0]            req_valid,
    input  logic [REQUESTERS-1:0]            req_enable,
    input  logic [REQUESTERS-1:0]            req_sign,
    input  logic [REQUESTERS*WORD_WIDTH-1:0] req_A,
    input  logic [REQUESTERS*WORD_WIDTH-1:0] req_B,
    output logic [REQUESTERS-1:0]            req_ready,
    output logic                             mult_sign,
    output logic [WORD_WIDTH-1:0]            mult_A,
    output logic [WORD_WIDTH-1:0]            mult_B,
    input  logic [WORD_WIDTH-1:0]            mult_R_lo,
    input  logic [WORD_WIDTH-1:0]            mult_R_hi,
    output logic [REQUESTERS-1:0]            resp_valid,
    output logic [WORD_WIDTH-1:0]            resp_lo,
    output logic [WORD_WIDTH-1:0]            resp_hi,
    output logic                             busy
);

    localparam int unsigned CNT_W = clog2(MAX_OUTSTANDING + 1);

    logic [REQUESTERS-1:0] eligible;
    logic                  grant_any;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q [REQUESTERS];
    logic [CNT_W-1:0]      cnt_d [REQUESTERS];
    logic                  tail_valid;
    logic [ID_WIDTH-1:0]   tail_id;
    logic [ID_WIDTH-1:0]   cand_id;
    int unsigned           cand;

    // Eligibility looks at the count before this cycle's response is retired.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            eligible[i] = req_valid[i] & req_enable[i]
                        & (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = 0;
        cand_id   = '0;
        if (!reset) begin
            for (int k = 0; k < REQUESTERS; k++) begin
                cand    = (int'(ptr_q) + k) % REQUESTERS;
                cand_id = ID_WIDTH'(cand);
                if (!grant_any && eligible[cand_id]) begin
                    grant_any = 1'b1;
                    grant_id  = cand_id;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            req_ready[i] = grant_any && (grant_id == ID_WIDTH'(i));
        end
    end

    always_comb begin
        mult_A    = '0;
        mult_B    = '0;
        mult_sign = 1'b0;
        if (grant_any) begin
            mult_A    = req_A[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
            mult_B    = req_B[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
            mult_sign = req_sign[grant_id];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == ID_WIDTH'(REQUESTERS - 1)) ? '0 : grant_id + ID_WIDTH'(1);
        end
    end

    mult_tag_pipe #(
        .DEPTH    (MULT_LATENCY),
        .ID_WIDTH (ID_WIDTH)
    ) u_tag_pipe (
        .clk_i   (clock),
        .rst_i   (reset),
        .valid_i (grant_any),
        .id_i    (grant_id),
        .valid_o (tail_valid),
        .id_o    (tail_id),
        .busy_o  (busy)
    );

    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            resp_valid[i] = tail_valid && (tail_id == ID_WIDTH'(i));
        end
    end

    assign resp_lo = mult_R_lo;
    assign resp_hi = mult_R_hi;

    // Accept and retire in the same cycle cancel out.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_ready[i] && !resp_valid[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!req_ready[i] && resp_valid[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            for (int i = 0; i < REQUESTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < REQUESTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
